// File: rtl/frame_scan_sequencer_pkg.sv
// Shared definitions for the frame scan sequencer and the per-pixel controller.
package frame_scan_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_PRED,
        OP_RESID,
        OP_FLUSH
    } ctrl_op_e;

    localparam int DEF_IMG_W = 512;
    localparam int DEF_IMG_H = 512;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_ISSUE   = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT    = 3'd2;
    localparam logic [ST_W-1:0] ST_ADVANCE = 3'd3;
    localparam logic [ST_W-1:0] ST_FIN     = 3'd4;

    // Counter width that stays legal for a dimension of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_scan_sequencer_raster_counter.sv
// Raster position tracker: row/col, pixel pointer and edge flags.
module frame_scan_sequencer_raster_counter
    import frame_scan_sequencer_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] ptr,
    output logic              last_pixel,
    output logic              first_row,
    output logic              first_col
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_col;

    assign last_col   = (col == COL_W'(IMG_W - 1));
    assign last_pixel = last_col && (row == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            col       <= '0;
            row       <= '0;
            first_row <= 1'b1;
            first_col <= 1'b1;
        end else if (load) begin
            ptr       <= base;
            col       <= '0;
            row       <= '0;
            first_row <= 1'b1;
            first_col <= 1'b1;
        end else if (advance) begin
            ptr <= ptr + ADDR_W'(1);
            if (last_col) begin
                col       <= '0;
                row       <= row + ROW_W'(1);
                first_col <= 1'b1;
                first_row <= 1'b0;
            end else begin
                col       <= col + COL_W'(1);
                first_col <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/frame_scan_sequencer.sv
// Frame-level raster scheduler issuing one pixel job at a time.
module frame_scan_sequencer
    import frame_scan_sequencer_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int ADDR_W  = 18,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    input  logic              out_ready,
    input  logic              pix_done,
    output logic              pix_start,
    output logic [ADDR_W-1:0] ptr,
    output logic              edge_case_first_row,
    output logic              edge_case_first_col,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pix_count,
    output logic              err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [ST_W-1:0] state;
    logic [WD_W-1:0] wd;
    logic            load;
    logic            advance;
    logic            last_pixel;
    logic            wd_expired;

    always_comb begin
        load       = (state == ST_IDLE) && start;
        advance    = (state == ST_ADVANCE) && !abort && !last_pixel;
        wd_expired = (wd == WD_W'(TIMEOUT - 1)) && !pix_done;
    end

    frame_scan_sequencer_raster_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_raster_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
        .base       (base_addr),
        .ptr        (ptr),
        .last_pixel (last_pixel),
        .first_row  (edge_case_first_row),
        .first_col  (edge_case_first_col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wd        <= '0;
            pix_start <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            pix_count <= '0;
            err       <= 1'b0;
        end else begin
            pix_start <= 1'b0;
            done      <= 1'b0;
            // Abort outranks completion, timeout and protocol errors.
            if (state != ST_IDLE && abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                if (pix_done && state != ST_WAIT) begin
                    err <= 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state     <= ST_ISSUE;
                            busy      <= 1'b1;
                            pix_count <= '0;
                            err       <= pix_done;
                        end
                    end
                    ST_ISSUE: begin
                        if (out_ready) begin
                            pix_start <= 1'b1;
                            wd        <= '0;
                            state     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (pix_done) begin
                            pix_count <= pix_count + ADDR_W'(1);
                            state     <= ST_ADVANCE;
                        end else if (wd_expired) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            wd <= wd + WD_W'(1);
                        end
                    end
                    ST_ADVANCE: begin
                        if (last_pixel) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                    ST_FIN: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_scan_sequencer.sv
// Scoreboard bench: randomized frames checked against a raster-order reference.
module tb_frame_scan_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 18;
    localparam int TO = 20;
    localparam int N  = W * H;

    typedef struct {
        logic [AW-1:0] ptr;
        logic          fr;
        logic          fc;
    } job_t;

    typedef struct {
        int done;
        int err;
        int cnt;
        int to_len;
    } end_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          abort;
    logic          out_ready;
    logic          pix_done;
    logic          resp_done;
    logic          resp_abort;
    logic          spur_done;
    logic          pix_start;
    logic [AW-1:0] ptr;
    logic          efr;
    logic          efc;
    logic          busy;
    logic          done;
    logic [AW-1:0] pix_count;
    logic          err;

    logic          start_b;
    logic [AW-1:0] base_b;
    logic          pix_done_b;
    logic          pix_start_b;
    logic [AW-1:0] ptr_b;
    logic          efr_b;
    logic          efc_b;
    logic          busy_b;
    logic          done_b;
    logic [AW-1:0] cnt_b;
    logic          err_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    job_t q_job[$];
    job_t q_job_b[$];
    end_t q_end[$];
    end_t q_end_b[$];

    int withhold_idx = -1;
    int abort_idx    = -1;
    int stall_idx    = -1;
    bit rand_ready   = 1'b0;
    bit rand_lat     = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign pix_done = resp_done | spur_done;
    assign abort    = resp_abort;

    frame_scan_sequencer #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .base_addr           (base_addr),
        .abort               (abort),
        .out_ready           (out_ready),
        .pix_done            (pix_done),
        .pix_start           (pix_start),
        .ptr                 (ptr),
        .edge_case_first_row (efr),
        .edge_case_first_col (efc),
        .busy                (busy),
        .done                (done),
        .pix_count           (pix_count),
        .err                 (err)
    );

    frame_scan_sequencer #(
        .IMG_W(4), .IMG_H(1), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut_b (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start_b),
        .base_addr           (base_b),
        .abort               (1'b0),
        .out_ready           (1'b1),
        .pix_done            (pix_done_b),
        .pix_start           (pix_start_b),
        .ptr                 (ptr_b),
        .edge_case_first_row (efr_b),
        .edge_case_first_col (efc_b),
        .busy                (busy_b),
        .done                (done_b),
        .pix_count           (cnt_b),
        .err                 (err_b)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference job list: raster order from base, pointer wraps mod 2^AW.
    task automatic push_jobs(input logic [AW-1:0] b, input int nj,
                             input int w, input bit to_b);
        job_t j;
        for (int i = 0; i < nj; i++) begin
            j.ptr = AW'((int'(b) + i) % (1 << AW));
            j.fr  = (i < w);
            j.fc  = (i % w == 0);
            if (to_b) q_job_b.push_back(j);
            else q_job.push_back(j);
        end
    endtask

    // Monitor for the main instance.
    bit prev_busy  = 1'b0;
    bit prev_ready = 1'b1;
    int done_seen  = 0;
    int last_start = 0;
    always @(negedge clk) begin
        job_t j;
        end_t e;
        if (pix_start) begin
            check("issue_without_ready", prev_ready, 1);
            last_start = cyc;
            if (q_job.size() == 0) begin
                check("unexpected_pix_start", 1, 0);
            end else begin
                j = q_job.pop_front();
                check("ptr", ptr, j.ptr);
                check("first_row", efr, j.fr);
                check("first_col", efc, j.fc);
            end
        end
        if (done) done_seen++;
        if (prev_busy && !busy) begin
            if (q_end.size() == 0) begin
                check("unexpected_frame_end", 1, 0);
            end else begin
                e = q_end.pop_front();
                check("done_pulses", done_seen, e.done);
                check("err_at_end", err, e.err);
                check("pix_count", pix_count, e.cnt);
                check("jobs_missing", q_job.size(), 0);
                if (e.to_len > 0)
                    check("wait_cycles", cyc - last_start, e.to_len);
            end
            done_seen = 0;
        end
        prev_busy  = busy;
        prev_ready = out_ready;
    end

    // Monitor for the wrap-around instance.
    bit prev_busy_b = 1'b0;
    int done_seen_b = 0;
    always @(negedge clk) begin
        job_t j;
        end_t e;
        if (pix_start_b) begin
            if (q_job_b.size() == 0) begin
                check("b_unexpected_pix_start", 1, 0);
            end else begin
                j = q_job_b.pop_front();
                check("b_ptr", ptr_b, j.ptr);
                check("b_first_row", efr_b, j.fr);
                check("b_first_col", efc_b, j.fc);
            end
        end
        if (done_b) done_seen_b++;
        if (prev_busy_b && !busy_b) begin
            if (q_end_b.size() == 0) begin
                check("b_unexpected_frame_end", 1, 0);
            end else begin
                e = q_end_b.pop_front();
                check("b_done_pulses", done_seen_b, e.done);
                check("b_err", err_b, e.err);
                check("b_pix_count", cnt_b, e.cnt);
                check("b_jobs_missing", q_job_b.size(), 0);
            end
            done_seen_b = 0;
        end
        prev_busy_b = busy_b;
    end

    // Per-pixel controller stand-in plus output-buffer readiness.
    initial begin
        int pend;
        int stall;
        int cur;
        int job_idx;
        bit pbusy;
        resp_done  = 1'b0;
        resp_abort = 1'b0;
        out_ready  = 1'b1;
        pend = 0; stall = 0; cur = 0; job_idx = 0; pbusy = 1'b0;
        forever begin
            @(posedge clk); #1;
            resp_done  = 1'b0;
            resp_abort = 1'b0;
            if (rst) pend = 0;
            if (busy && !pbusy) job_idx = 0;
            pbusy = busy;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    resp_done = 1'b1;
                    if (cur == abort_idx) resp_abort = 1'b1;
                    if (cur == stall_idx - 1) stall = 5;
                end
            end
            if (pix_start) begin
                cur = job_idx;
                job_idx++;
                if (cur != withhold_idx)
                    pend = rand_lat ? int'($urandom_range(1, 4)) : 2;
            end
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    initial begin
        pix_done_b = 1'b0;
        forever begin
            @(posedge clk); #1;
            pix_done_b = pix_start_b;
        end
    end

    task automatic frame(input logic [AW-1:0] b, input int nj,
                         input int e_done, input int e_err,
                         input int e_cnt, input int e_to, input bit poke);
        int k;
        push_jobs(b, nj, W, 1'b0);
        q_end.push_back('{e_done, e_err, e_cnt, e_to});
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom);
        check("err_cleared_by_start", err, 0);
        k = 0;
        while (busy && k < 3000) begin
            @(posedge clk); #1;
            start = poke && (k % 7 == 3);
            base_addr = AW'($urandom);
            k++;
        end
        start = 1'b0;
        check("frame_finished_in_bound", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        spur_done = 1'b0;
        start_b = 1'b0;
        base_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ptr", ptr, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_err", err, 0);
        check("rst_first_row", efr, 1);
        check("rst_first_col", efc, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pix_start", pix_start, 0);
        @(negedge clk);
        rst = 1'b0;

        frame(AW'(100), N, 1, 0, N, 0, 1'b0);

        stall_idx = 5;
        frame(AW'(100), N, 1, 0, N, 0, 1'b0);
        stall_idx = -1;

        withhold_idx = 2;
        frame(AW'(300), 3, 0, 1, 2, TO, 1'b0);
        withhold_idx = -1;

        abort_idx = 4;
        frame(AW'(100), 5, 0, 0, 4, 0, 1'b0);
        abort_idx = -1;

        @(posedge clk); #1;
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        @(posedge clk); #1;
        check("spurious_done_err", err, 1);
        check("spurious_done_busy", busy, 0);
        check("spurious_done_count", pix_count, 4);

        frame(AW'(100), N, 1, 0, N, 0, 1'b1);

        rand_ready = 1'b1;
        rand_lat   = 1'b1;
        for (int f = 0; f < 4; f++)
            frame(AW'($urandom), N, 1, 0, N, 0, f[0]);
        rand_ready = 1'b0;
        rand_lat   = 1'b0;

        // Asynchronous reset in the middle of a frame.
        push_jobs(AW'(500), 3, W, 1'b0);
        q_end.push_back('{0, 0, 0, 0});
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'(500);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (q_job.size() != 0 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("jobs_before_reset", q_job.size(), 0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_ptr", ptr, 0);
        check("async_rst_count", pix_count, 0);
        check("async_rst_first_col", efc, 1);
        @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Pointer wrap on a single-row image.
        push_jobs(AW'((1 << AW) - 2), 4, 4, 1'b1);
        q_end_b.push_back('{1, 0, 4, 0});
        @(posedge clk); #1;
        start_b = 1'b1;
        base_b = AW'((1 << AW) - 2);
        @(posedge clk); #1;
        start_b = 1'b0;
        k = 0;
        while (busy_b && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("b_finished_in_bound", busy_b, 0);
        repeat (3) @(posedge clk);
        #1;
        check("end_queue_drained", q_end.size() + q_end_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

endmodule
